// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 opcodes, fetch state type and instruction format helpers
// Shared by the fetch stage and its byte queue. No ports.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    // Longest instruction in bytes; also the width of the decode peek window.
    localparam int MAX_LEN = 10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } fetch_state_e;

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:              instr_len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  instr_len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      instr_len = 4'd10;
            I_JXX, I_CALL:                     instr_len = 4'd9;
            default:                           instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:            has_regs = 1'b1;
            default:                           has_regs = 1'b0;
        endcase
    endfunction

    function automatic logic has_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:                     has_valc = 1'b1;
            default:                           has_valc = 1'b0;
        endcase
    endfunction

    // Instructions with a register byte carry valC at offset 2, jumps/calls at offset 1.
    function automatic logic valc_at2(input logic [3:0] icode);
        valc_at2 = (icode == I_IRMOVQ) || (icode == I_RMMOVQ) || (icode == I_MRMOVQ);
    endfunction

    function automatic logic is_legal(input logic [3:0] icode);
        is_legal = (icode <= I_POPQ);
    endfunction

endpackage

// File: rtl/fetch_byte_q.sv
// rtl/fetch_byte_q.sv - circular byte buffer with wide push, variable pop and peek window
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_flush        empty the buffer (wins over push/pop)
//   i_push         write BUS_BYTES bytes from i_push_data (byte k in bits [8k+7:8k])
//   i_pop_n        number of bytes to drop from the head (0..MAX_LEN)
//   o_peek         MAX_LEN bytes starting at the head, head byte in bits [7:0]
//   o_count        bytes currently held (0..QDEPTH)
module fetch_byte_q
    import y86_pkg::*;
#(
    parameter int  QDEPTH    = 16,
    parameter int  BUS_BYTES = 2,
    localparam int PW        = $clog2(QDEPTH),
    localparam int CW        = $clog2(QDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [8*BUS_BYTES-1:0] i_push_data,
    input  logic [3:0]             i_pop_n,
    output logic [8*MAX_LEN-1:0]   o_peek,
    output logic [CW-1:0]          o_count
);

    logic [7:0]    r_mem [QDEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + PW'(BUS_BYTES);
            end
            r_rd    <= r_rd + PW'(i_pop_n);
            r_count <= r_count + (i_push ? CW'(BUS_BYTES) : CW'(0)) - CW'(i_pop_n);
        end
    end

    // Storage carries no reset: bytes are only observed once counted in.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            for (int k = 0; k < BUS_BYTES; k++) begin
                r_mem[r_wr + PW'(k)] <= i_push_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        o_peek = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            o_peek[8*k +: 8] = r_mem[r_rd + PW'(k)];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_q.sv
// rtl/fetch_prefetch_q.sv - Y86-64 fetch stage with byte prefetch queue
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//   mem_req_*                       read request (valid/ready), address = fetch pointer
//   mem_rsp_*                       read beat of BUS_BYTES bytes, err marks whole beat bad
//   out_valid, out_ready            decoded record handshake to decode
//   pc .. hlt                       decoded record fields
module fetch_prefetch_q
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int BUS_BYTES = 2,
    parameter int QDEPTH    = 16,
    parameter int MEM_BYTES = 1024,
    parameter int VALC_LE   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_W-1:0]      mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [8*BUS_BYTES-1:0] mem_rsp_data,
    input  logic                   mem_rsp_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      pc,
    output logic [3:0]             icode,
    output logic [3:0]             ifun,
    output logic [3:0]             rA,
    output logic [3:0]             rB,
    output logic [63:0]            valC,
    output logic [ADDR_W-1:0]      valP,
    output logic                   instr_valid,
    output logic                   imem_error,
    output logic                   hlt
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e        r_state;
    logic [ADDR_W-1:0]   r_fpc;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_outst;
    logic                r_drop;
    logic                r_err_pend;

    logic [8*MAX_LEN-1:0] w_peek;
    logic [CW-1:0]        w_count;
    logic [7:0]           w_b [MAX_LEN];
    logic [7:0]           w_byte0;
    logic [3:0]           w_icode;
    logic [3:0]           w_len;
    logic                 w_full_instr;
    logic                 w_err_rec;
    logic                 w_accept;
    logic                 w_stop;
    logic [3:0]           w_pop_n;
    logic [63:0]          w_valc_raw;
    logic [CW-1:0]        w_free;
    logic                 w_can_issue;
    logic                 w_addr_bad;
    logic                 w_req_fire;
    logic                 w_rsp_take;
    logic                 w_push;

    fetch_byte_q #(
        .QDEPTH    (QDEPTH),
        .BUS_BYTES (BUS_BYTES)
    ) u_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (mem_rsp_data),
        .i_pop_n     (w_pop_n),
        .o_peek      (w_peek),
        .o_count     (w_count)
    );

    // ---------------- decode of the queue head ----------------
    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            w_b[k] = w_peek[8*k +: 8];
        end
    end

    // An empty queue decodes as opcode 0 so an error record on it is deterministic.
    assign w_byte0      = (w_count == '0) ? 8'h00 : w_b[0];
    assign w_icode      = w_byte0[7:4];
    assign w_len        = instr_len(w_icode);
    assign w_full_instr = (w_count >= CW'(w_len));
    assign w_err_rec    = !w_full_instr;
    assign out_valid    = (r_state == ST_RUN) && (w_full_instr || r_err_pend);

    always_comb begin
        w_valc_raw = '0;
        for (int j = 0; j < 8; j++) begin
            if (VALC_LE != 0) begin
                w_valc_raw[8*j +: 8]     = valc_at2(w_icode) ? w_b[j+2] : w_b[j+1];
            end else begin
                w_valc_raw[8*(7-j) +: 8] = valc_at2(w_icode) ? w_b[j+2] : w_b[j+1];
            end
        end
    end

    // Record fields read as idle values whenever no record is offered.
    always_comb begin
        pc          = r_pc;
        icode       = 4'h0;
        ifun        = 4'h0;
        rA          = REG_NONE;
        rB          = REG_NONE;
        valC        = '0;
        valP        = '0;
        instr_valid = 1'b0;
        imem_error  = 1'b0;
        hlt         = 1'b0;
        if (out_valid) begin
            icode = w_icode;
            ifun  = w_byte0[3:0];
            if (has_regs(w_icode) && (w_count >= CW'(2))) begin
                rA = w_b[1][7:4];
                rB = w_b[1][3:0];
            end
            if (!w_err_rec && has_valc(w_icode)) begin
                valC = w_valc_raw;
            end
            valP        = w_err_rec ? r_pc : r_pc + ADDR_W'(w_len);
            instr_valid = is_legal(w_icode);
            imem_error  = w_err_rec;
            hlt         = !w_err_rec && (w_icode == I_HALT);
        end
    end

    assign w_accept = out_valid && out_ready;
    assign w_stop   = hlt || !instr_valid || imem_error;
    // Error records leave the queue alone; the stage stops and a redirect flushes it.
    assign w_pop_n  = (w_accept && !w_err_rec) ? w_len : 4'd0;

    // ---------------- memory request / response ----------------
    assign w_free      = CW'(QDEPTH) - w_count;
    // rst_n gating keeps the request quiet while reset is held.
    assign w_can_issue = rst_n && (r_state == ST_RUN) && !r_outst && !r_err_pend &&
                         !redirect_valid && (w_free >= CW'(BUS_BYTES));
    assign w_addr_bad  = (r_fpc >= ADDR_W'(MEM_BYTES));
    assign mem_req_valid = w_can_issue && !w_addr_bad;
    assign mem_req_addr  = r_fpc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign w_rsp_take    = mem_rsp_valid && r_outst;
    assign w_push        = w_rsp_take && !r_drop && !mem_rsp_err && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fpc      <= '0;
            r_pc       <= '0;
            r_outst    <= 1'b0;
            r_drop     <= 1'b0;
            r_err_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_fpc      <= redirect_pc;
            r_pc       <= redirect_pc;
            r_err_pend <= 1'b0;
            // A beat still in flight belongs to the old stream: wait for it and drop it.
            r_outst    <= r_outst && !mem_rsp_valid;
            r_drop     <= r_outst && !mem_rsp_valid;
        end else begin
            if (w_req_fire) begin
                r_outst <= 1'b1;
                r_fpc   <= r_fpc + ADDR_W'(BUS_BYTES);
            end
            if (w_rsp_take) begin
                r_outst <= 1'b0;
                r_drop  <= 1'b0;
                if (!r_drop && mem_rsp_err) begin
                    r_err_pend <= 1'b1;
                end
            end
            if (w_can_issue && w_addr_bad) begin
                r_err_pend <= 1'b1;
            end
            if (w_accept) begin
                r_pc <= valP;
                if (w_stop) begin
                    r_state <= ST_STOP;
                end
            end
        end
    end

endmodule
